// File: rtl/padlock_entry_ctrl.sv
// padlock_entry_ctrl: keypad entry sequencer for the combination padlock.
// Tracks digit entry against the stored code, counts failed attempts,
// enforces a timed lockout and allows re-programming from UNLOCKED.
module padlock_entry_ctrl #(
  parameter int CODE_LEN       = 4,
  parameter int DIGIT_W        = 3,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 12'h8D1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIGIT_W-1:0]               digit,
  input  logic                             digit_valid,
  input  logic                             enter,
  input  logic                             clear,
  input  logic                             lock_req,
  input  logic                             prog_req,
  output logic                             unlocked,
  output logic                             prog_mode,
  output logic                             lockout,
  output logic                             err_pulse,
  output logic                             prog_done,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);
  localparam int CODE_W = CODE_LEN * DIGIT_W;

  typedef enum logic [1:0] {
    S_LOCKED,
    S_UNLOCKED,
    S_PROG,
    S_LOCKOUT
  } state_t;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                mis_q, mis_n;
  logic [CODE_W-1:0]   code_q, code_n;
  logic [CODE_W-1:0]   shadow_q, shadow_n;
  logic [TRY_W-1:0]    tries_q, tries_n;
  logic [TMR_W-1:0]    timer_q, timer_n;
  logic                err_n, done_n;
  logic [DIGIT_W-1:0]  cur_dig;
  logic                full;

  assign tries_left = tries_q;

  // Next-state, entry tracking and pulse generation; clear > enter > digit_valid.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    mis_n    = mis_q;
    code_n   = code_q;
    shadow_n = shadow_q;
    tries_n  = tries_q;
    timer_n  = timer_q;
    err_n    = 1'b0;
    done_n   = 1'b0;
    cur_dig  = '0;
    full     = (cnt_q == CNT_W'(CODE_LEN));

    for (int unsigned i = 0; i < CODE_LEN; i++) begin
      if (cnt_q == CNT_W'(i)) cur_dig = code_q[i*DIGIT_W +: DIGIT_W];
    end

    case (state_q)
      S_LOCKED: begin
        if (clear) begin
          cnt_n = '0;
          mis_n = 1'b0;
        end else if (enter) begin
          // An empty entry is not an attempt: no error, no try consumed.
          if (cnt_q != '0) begin
            cnt_n = '0;
            mis_n = 1'b0;
            if (full && !mis_q) begin
              state_n = S_UNLOCKED;
              tries_n = TRY_W'(MAX_TRIES);
            end else begin
              err_n   = 1'b1;
              tries_n = tries_q - TRY_W'(1);
              if (tries_q == TRY_W'(1)) begin
                state_n = S_LOCKOUT;
                timer_n = TMR_W'(LOCKOUT_CYCLES - 1);
              end
            end
          end
        end else if (digit_valid) begin
          if (full) begin
            mis_n = 1'b1;
          end else begin
            if (digit != cur_dig) mis_n = 1'b1;
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end

      S_UNLOCKED: begin
        if (lock_req) begin
          state_n = S_LOCKED;
        end else if (prog_req) begin
          state_n  = S_PROG;
          cnt_n    = '0;
          mis_n    = 1'b0;
          shadow_n = '0;
        end
      end

      S_PROG: begin
        if (lock_req) begin
          state_n  = S_LOCKED;
          cnt_n    = '0;
          mis_n    = 1'b0;
          shadow_n = '0;
        end else if (clear) begin
          cnt_n = '0;
          mis_n = 1'b0;
        end else if (enter) begin
          if (full && !mis_q) begin
            code_n  = shadow_q;
            done_n  = 1'b1;
            state_n = S_UNLOCKED;
          end else begin
            err_n = 1'b1;
          end
          cnt_n    = '0;
          mis_n    = 1'b0;
          shadow_n = '0;
        end else if (digit_valid) begin
          if (full) begin
            mis_n = 1'b1;
          end else begin
            for (int unsigned i = 0; i < CODE_LEN; i++) begin
              if (cnt_q == CNT_W'(i)) shadow_n[i*DIGIT_W +: DIGIT_W] = digit;
            end
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
      end

      S_LOCKOUT: begin
        // Timer is loaded with LOCKOUT_CYCLES-1 so the state lasts exactly LOCKOUT_CYCLES.
        if (timer_q == '0) begin
          state_n = S_LOCKED;
          tries_n = TRY_W'(MAX_TRIES);
          cnt_n   = '0;
          mis_n   = 1'b0;
        end else begin
          timer_n = timer_q - TMR_W'(1);
        end
      end

      default: state_n = S_LOCKED;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOCKED;
      cnt_q     <= '0;
      mis_q     <= 1'b0;
      code_q    <= DEFAULT_CODE;
      shadow_q  <= '0;
      tries_q   <= TRY_W'(MAX_TRIES);
      timer_q   <= '0;
      unlocked  <= 1'b0;
      prog_mode <= 1'b0;
      lockout   <= 1'b0;
      err_pulse <= 1'b0;
      prog_done <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      mis_q     <= mis_n;
      code_q    <= code_n;
      shadow_q  <= shadow_n;
      tries_q   <= tries_n;
      timer_q   <= timer_n;
      unlocked  <= (state_n == S_UNLOCKED) || (state_n == S_PROG);
      prog_mode <= (state_n == S_PROG);
      lockout   <= (state_n == S_LOCKOUT);
      err_pulse <= err_n;
      prog_done <= done_n;
    end
  end

endmodule

// File: doc/padlock_entry_ctrl.md
Name: padlock_entry_ctrl

Overview:
Sequencing controller for the combination padlock. It accepts keypad digits one at a time and compares them against a stored code. It counts failed attempts, enforces a timed lockout, and supports re-programming the code from the unlocked state. It sits between the debounced input pins and the lock/indicator outputs of the padlock design.

Parameters:
- CODE_LEN, 4, number of digits in a combination.
- DIGIT_W, 3, bits per digit.
- MAX_TRIES, 3, consecutive failed attempts allowed before lockout (>=1).
- LOCKOUT_CYCLES, 1000, clock cycles spent in lockout (>=2).
- DEFAULT_CODE, 12'h8D1, reset code, CODE_LEN*DIGIT_W bits. Digit i occupies bits [i*DIGIT_W +: DIGIT_W]; digit 0 is entered first. The default is the sequence 1,2,3,4.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- digit  in  DIGIT_W  keypad digit value, sampled only when digit_valid=1.
- digit_valid  in  1  one-cycle strobe, already synchronised and debounced.
- enter  in  1  one-cycle strobe: submit the current entry.
- clear  in  1  one-cycle strobe: discard the current entry.
- lock_req  in  1  one-cycle strobe: relock, or abort programming.
- prog_req  in  1  one-cycle strobe: enter programming mode (UNLOCKED only).
- unlocked  out  1  registered, high in UNLOCKED and PROG.
- prog_mode  out  1  registered, high in PROG.
- lockout  out  1  registered, high in LOCKOUT.
- err_pulse  out  1  one-cycle pulse on a rejected enter.
- prog_done  out  1  one-cycle pulse when a new code is committed.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts.

Behaviour:
- Reset (one cycle of rst=1):
  - state=LOCKED, code=DEFAULT_CODE, tries_left=MAX_TRIES.
  - Digit count and mismatch flag cleared.
  - unlocked, prog_mode, lockout, err_pulse and prog_done all 0.
  - Reset in any state, including mid-lockout or mid-programming, returns to these values. The code reverts to DEFAULT_CODE.
- Input priority within one cycle: clear > enter > digit_valid. A lower-priority strobe in the same cycle is dropped. lock_req beats prog_req.
- Entry tracking:
  - cnt counts digits, range 0..CODE_LEN, saturating. A mismatch flag is kept alongside it.
  - A digit at cnt<CODE_LEN compares against code digit[cnt]; on inequality it sets mismatch, then cnt increments.
  - A digit at cnt==CODE_LEN (too long) sets mismatch; cnt stays.
  - clear zeroes cnt and mismatch, with no other effect.
- LOCKED:
  - digit_valid updates the entry tracking.
  - enter with cnt==0: ignored, no error, no try consumed.
  - enter with cnt==CODE_LEN and mismatch==0: next cycle UNLOCKED, unlocked=1, tries_left=MAX_TRIES.
  - Any other enter: err_pulse=1 next cycle and tries_left decrements.
    - If tries_left was 1: go to LOCKOUT, tries_left=0, timer loaded.
  - cnt and mismatch clear on every accepted enter.
  - lock_req and prog_req are ignored.
- UNLOCKED:
  - lock_req: go to LOCKED.
  - prog_req: go to PROG with cnt=0.
  - digit_valid, enter and clear are ignored.
- PROG:
  - digit_valid at cnt<CODE_LEN writes the digit into a shadow register at slot cnt, then cnt increments.
  - A digit at cnt==CODE_LEN sets mismatch (overlong).
  - enter with cnt==CODE_LEN and no overflow: shadow is copied to code, prog_done=1 for one cycle, state returns to UNLOCKED.
  - Any other enter: err_pulse=1, stay in PROG, shadow/cnt/mismatch cleared.
  - lock_req: go to LOCKED, code unchanged, shadow discarded.
  - prog_req is ignored.
- LOCKOUT:
  - All strobes are ignored.
  - lockout=1 for exactly LOCKOUT_CYCLES cycles.
  - Then LOCKED with tries_left=MAX_TRIES and cnt=0.
  - The timer is width $clog2(LOCKOUT_CYCLES+1) and has no wrap-around.
- Latency: every strobe takes effect on the registered outputs at the next rising edge (1 cycle).
- err_pulse and prog_done are never high simultaneously and never high for 2 consecutive cycles from one strobe.

Test Plan:
- Reset, then digits 1,2,3,4, then enter -> 1 cycle later unlocked=1, tries_left=3, err_pulse=0.
- Digits 1,2,3,5, then enter -> err_pulse for 1 cycle, tries_left=2, unlocked=0. Then digits 1,2,3,4,4 (overlong), then enter -> err_pulse, tries_left=1.
- Three wrong entries with LOCKOUT_CYCLES=16 -> lockout=1 for exactly 16 cycles. A correct code entered during lockout is ignored. Afterwards state is LOCKED with tries_left=3.
- Unlock, prog_req, digits 7,0,7,0, enter -> prog_done pulse. Then lock_req, then old code 1,2,3,4 -> err_pulse. Then new code 7,0,7,0 -> unlocked=1.
- In PROG, digits 5,5 then enter -> err_pulse and code unchanged. lock_req mid-entry -> LOCKED. Reset asserted in the middle of lockout -> lockout=0, code=1,2,3,4.
- Same-cycle digit_valid+enter -> digit dropped. clear+enter -> entry cleared with no error and tries unchanged. lock_req+prog_req in UNLOCKED -> LOCKED.
